// File: rtl/loadarch_injector.sv
// loadarch_injector
//   Loads an architectural register image and an optional PC from a host. It
//   then replays the image into the core as register writes. It holds the
//   core fetch PC forced until the core has left reset for HOLD cycles.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   in_valid/in_ready     host image-word handshake (ready only while loading)
//   in_idx/in_data/in_last  target (0..NREGS-1 register, NREGS = PC), word, final flag
//   core_reset            observed core reset level
//   wr_valid/wr_ready     register write request to the core
//   wr_addr/wr_data       register index and value
//   pc_force/pc_value     fetch PC override
//   done                  injection and PC release complete
//   error                 sticky protocol error
module loadarch_injector #(
    parameter int             XLEN       = 64,
    parameter int             NREGS      = 32,
    parameter int             PCW        = 40,
    parameter logic [PCW-1:0] DEFAULT_PC = 40'h8000_0000,
    parameter int             HOLD       = 2,
    localparam int            IDXW       = $clog2(NREGS + 1),
    localparam int            AW         = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IDXW-1:0] in_idx,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_last,
    input  logic            core_reset,
    output logic            wr_valid,
    input  logic            wr_ready,
    output logic [AW-1:0]   wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic            pc_force,
    output logic [PCW-1:0]  pc_value,
    output logic            done,
    output logic            error
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_INJECT,
        S_WAIT_RST,
        S_HOLD_PC,
        S_DONE
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   image [NREGS];
    logic [NREGS-1:0]  vbits;
    logic [AW-1:0]     ptr;
    logic [31:0]       hcnt;
    logic              seen_hi;
    logic              fell;
    logic              fell_now;
    logic              in_reg;
    logic              in_pc;

    // The flag counts as set in the same cycle the falling sample is taken.
    // WAIT_RST therefore reacts without an extra cycle of latency.
    assign fell_now = fell | (seen_hi & ~core_reset);

    assign in_reg = in_idx <  IDXW'(NREGS);
    assign in_pc  = in_idx == IDXW'(NREGS);

    // The write request is decoded only from registered state and pointer.
    // There is no input-to-output path, and the request stays stable while
    // it waits for wr_ready.
    assign wr_valid = (state == S_INJECT) && vbits[ptr];
    assign wr_addr  = ptr;
    assign wr_data  = image[ptr];

    // The image data needs no reset. Only its valid bits carry meaning.
    always_ff @(posedge clock) begin
        if (in_valid && in_ready && in_reg)
            image[in_idx[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_LOAD;
            vbits    <= '0;
            ptr      <= AW'(1);
            hcnt     <= '0;
            seen_hi  <= 1'b0;
            fell     <= 1'b0;
            in_ready <= 1'b1;
            pc_force <= 1'b1;
            // Reloading the default also serves as "no PC loaded".
            pc_value <= DEFAULT_PC;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            seen_hi <= seen_hi | core_reset;
            fell    <= fell_now;
            // If the core leaves reset before all registers are in place,
            // flag it. The sequence itself still completes.
            if (fell_now && (state == S_LOAD || state == S_INJECT))
                error <= 1'b1;

            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (in_reg)
                            vbits[in_idx[AW-1:0]] <= 1'b1;
                        else if (in_pc)
                            pc_value <= in_data[PCW-1:0];
                        else
                            error <= 1'b1;
                        if (in_last) begin
                            state    <= S_INJECT;
                            in_ready <= 1'b0;
                            ptr      <= AW'(1);
                        end
                    end
                end
                S_INJECT: begin
                    // Indices without a valid bit take one idle cycle each.
                    if (!vbits[ptr] || wr_ready) begin
                        if (ptr == AW'(NREGS - 1))
                            state <= S_WAIT_RST;
                        else
                            ptr <= ptr + AW'(1);
                    end
                end
                S_WAIT_RST: begin
                    if (fell_now) begin
                        if (HOLD == 0) begin
                            state    <= S_DONE;
                            pc_force <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= S_HOLD_PC;
                            hcnt  <= '0;
                        end
                    end
                end
                S_HOLD_PC: begin
                    if (hcnt == 32'(HOLD - 1)) begin
                        state    <= S_DONE;
                        pc_force <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 32'd1;
                    end
                end
                S_DONE: ;
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_loadarch_injector.sv
module tb_loadarch_injector;

    localparam logic [39:0] DEF_PC = 40'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_idx;
    logic [63:0] in_data;
    logic        in_last;
    logic        core_reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        pc_force;
    logic [39:0] pc_value;
    logic        done;
    logic        error;

    int passed = 0;
    int total  = 0;
    logic [4:0]  wa[$];
    logic [63:0] wd[$];

    loadarch_injector dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .in_data(in_data), .in_last(in_last), .core_reset(core_reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .pc_force(pc_force), .pc_value(pc_value),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wa.delete();
        wd.delete();
    endtask

    task automatic push(input int idx, input logic [63:0] d, input logic last);
        in_valid = 1'b1;
        in_idx   = 6'(idx);
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Steps n cycles and logs every accepted write.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (wr_valid && wr_ready) begin
                wa.push_back(wr_addr);
                wd.push_back(wr_data);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_idx = '0; in_data = '0; in_last = 1'b0;
        core_reset = 1'b1; wr_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Check the output values immediately after reset.
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_pc_force", pc_force, 1);
        chk("rst_pc_value", pc_value, DEF_PC);
        chk("rst_done",     done, 0);
        chk("rst_error",    error, 0);

        // Run the basic image: x1, x5, then the PC as the last word.
        push(1, 64'h11, 1'b0);
        push(5, 64'h55, 1'b0);
        push(32, 64'h8000_0100, 1'b1);
        chk("t1_in_ready_inject", in_ready, 0);
        run_cycles(40);
        chk("t1_nwrites", 64'(wa.size()), 2);
        chk("t1_w0_addr", wa[0], 1);
        chk("t1_w0_data", wd[0], 64'h11);
        chk("t1_w1_addr", wa[1], 5);
        chk("t1_w1_data", wd[1], 64'h55);
        chk("t1_pc_value", pc_value, 40'h8000_0100);
        chk("t1_wait_force", pc_force, 1);
        chk("t1_wait_done", done, 0);
        core_reset = 1'b0;
        tick();
        chk("t1_hold1_force", pc_force, 1);
        tick();
        chk("t1_hold2_force", pc_force, 1);
        tick();
        chk("t1_done_force", pc_force, 0);
        chk("t1_done", done, 1);
        chk("t1_done_ready", in_ready, 0);
        chk("t1_error", error, 0);
        tick();
        chk("t1_done_sticky", done, 1);

        // With no PC word, the default PC applies throughout.
        core_reset = 1'b1;
        do_reset();
        chk("t2_after_reset_done", done, 0);
        push(2, 64'h22, 1'b1);
        chk("t2_pc_inject", pc_value, DEF_PC);
        run_cycles(40);
        chk("t2_nwrites", 64'(wa.size()), 1);
        chk("t2_w0_addr", wa[0], 2);
        chk("t2_pc_wait", pc_value, DEF_PC);
        core_reset = 1'b0;
        tick(); tick();
        chk("t2_not_done_yet", done, 0);
        tick();
        chk("t2_done", done, 1);
        chk("t2_pc_done", pc_value, DEF_PC);

        // While wr_ready is low, the write request must stay stable.
        core_reset = 1'b1;
        do_reset();
        wr_ready = 1'b0;
        push(1, 64'hAA, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", wr_valid, 1);
            chk("t3_stall_addr", wr_addr, 1);
            chk("t3_stall_data", wr_data, 64'hAA);
            tick();
        end
        chk("t3_still_x1", wr_addr, 1);
        wr_ready = 1'b1;
        tick();
        chk("t3_advanced_valid", wr_valid, 0);
        chk("t3_advanced_addr", wr_addr, 2);

        // An out-of-range index sets the sticky error.
        do_reset();
        push(33, 64'hDEAD, 1'b0);
        chk("t4_error", error, 1);
        chk("t4_ready", in_ready, 1);
        push(3, 64'h33, 1'b1);
        run_cycles(40);
        chk("t4_nwrites", 64'(wa.size()), 1);
        chk("t4_w0_addr", wa[0], 3);
        chk("t4_error_sticky", error, 1);
        core_reset = 1'b0;
        tick(); tick(); tick();
        chk("t4_done", done, 1);

        // The core reset falls during LOAD: error is set, the sequence still completes.
        core_reset = 1'b1;
        do_reset();
        chk("t5_error_cleared", error, 0);
        tick();
        core_reset = 1'b0;
        tick();
        chk("t5_error", error, 1);
        push(4, 64'h44, 1'b1);
        chk("t5_injecting", pc_force, 1);
        run_cycles(40);
        chk("t5_nwrites", 64'(wa.size()), 1);
        chk("t5_w0_addr", wa[0], 4);
        chk("t5_done", done, 1);
        chk("t5_error_sticky", error, 1);

        // Reset mid-INJECT aborts the sequence and clears the image.
        core_reset = 1'b1;
        do_reset();
        push(1, 64'h1, 1'b0);
        push(2, 64'h2, 1'b0);
        push(32, 64'h1234, 1'b1);
        tick();
        chk("t6_pre_valid", wr_valid, 1);
        chk("t6_pre_addr", wr_addr, 2);
        chk("t6_pre_pc", pc_value, 40'h1234);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_ready", in_ready, 1);
        chk("t6_wr_valid", wr_valid, 0);
        chk("t6_pc", pc_value, DEF_PC);
        chk("t6_force", pc_force, 1);
        wa.delete();
        wd.delete();
        push(7, 64'h77, 1'b1);
        run_cycles(40);
        chk("t6_nwrites", 64'(wa.size()), 1);
        chk("t6_w0_addr", wa[0], 7);
        chk("t6_w0_data", wd[0], 64'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/loadarch_injector.md
LOADARCH_INJECTOR -- requirements
Module: loadarch_injector

Interface
REQ-001 SHALL have parameter XLEN, default 64, architectural register width.
REQ-002 SHALL have parameter NREGS, default 32, number of integer registers in the image.
REQ-003 SHALL have parameter PCW, default 40, width of the forced fetch PC.
REQ-004 SHALL have parameter DEFAULT_PC, default 40'h8000_0000, PC forced when no PC is loaded.
REQ-005 SHALL have parameter HOLD, default 2, cycles pc_force stays high after the core reset falls; HOLD >= 0.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clock  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high block reset.
REQ-009 in_valid  input  1  host image word valid.
REQ-010 in_ready  output  1  block accepts an image word.
REQ-011 in_idx  input  $clog2(NREGS+1)  target: 0..NREGS-1 register, NREGS = PC.
REQ-012 in_data  input  XLEN  image word.
REQ-013 in_last  input  1  final image word.
REQ-014 core_reset  input  1  observed core reset level.
REQ-015 wr_valid  output  1  register write request to core.
REQ-016 wr_ready  input  1  core accepts write.
REQ-017 wr_addr  output  $clog2(NREGS)  register index.
REQ-018 wr_data  output  XLEN  register value.
REQ-019 pc_force  output  1  override core fetch PC.
REQ-020 pc_value  output  PCW  forced PC.
REQ-021 done  output  1  injection and PC release complete.
REQ-022 error  output  1  sticky protocol error.

Function
REQ-023 SHALL implement FSM states LOAD, INJECT, WAIT_RST, HOLD_PC, DONE.
REQ-024 SHALL assert in_ready only in LOAD; handshake = in_valid && in_ready.
REQ-025 On handshake with in_idx < NREGS SHALL store in_data to image[in_idx] and set its valid bit; later writes to the same index overwrite.
REQ-026 On handshake with in_idx == NREGS SHALL store in_data[PCW-1:0] as the PC and mark PC loaded.
REQ-027 On handshake with in_idx > NREGS SHALL drop the data and set error.
REQ-028 On handshake with in_last SHALL go LOAD -> INJECT next cycle.
REQ-029 INJECT SHALL walk pointer 1..NREGS-1 (index 0 never written), one cycle per index without a valid bit, wr_valid only for valid indices.
REQ-030 wr_valid, wr_addr, wr_data SHALL hold stable until wr_ready; pointer advances on the wr_valid && wr_ready cycle.
REQ-031 After index NREGS-1 completes SHALL go INJECT -> WAIT_RST.
REQ-032 SHALL latch a falling-edge flag when core_reset is sampled 0 after being sampled 1 since block reset, in any state.
REQ-033 WAIT_RST SHALL go to HOLD_PC in the cycle the flag is set (including already set on entry); HOLD_PC counts HOLD cycles then goes to DONE; HOLD == 0 goes directly to DONE.
REQ-034 pc_force SHALL be 1 in all states except DONE; pc_value = loaded PC, else DEFAULT_PC.
REQ-035 DONE SHALL be terminal until reset: done = 1, pc_force = 0, wr_valid = 0, in_ready = 0.
REQ-036 If the flag is set before INJECT completes SHALL set error and still complete injection before HOLD_PC.
REQ-037 error SHALL stay set until reset.

Reset
REQ-038 On reset SHALL enter LOAD, clear all valid bits, PC-loaded, edge flag, counters; outputs: in_ready=1, wr_valid=0, pc_force=1, pc_value=DEFAULT_PC, done=0, error=0.
REQ-039 Reset asserted in any state SHALL abort the sequence next cycle, including a pending write.

Verification
REQ-040 Load x1=0x11, x5=0x55, PC=0x8000_0100 (last), wr_ready=1, core_reset 1->0 after injection -> writes (1,0x11),(5,0x55) only; pc_value 0x8000_0100; pc_force drops HOLD=2 cycles after falling edge; done=1.
REQ-041 No PC word, single last word x2 -> pc_value = 0x8000_0000 throughout; done follows core_reset fall.
REQ-042 wr_ready low 5 cycles on x1 write -> wr_valid/addr/data stable 5 cycles, no pointer advance.
REQ-043 in_idx = NREGS+1 (when representable) or core_reset falls during LOAD -> error=1 sticky; remaining sequence completes.
REQ-044 Reset pulsed during INJECT -> next cycle LOAD, wr_valid=0, pc_value=DEFAULT_PC, valid bits cleared.
